// File: rtl/audio_pkg.sv
// Shared types for the codec <-> FIR filter bridge: sample widths, the stereo
// pair carried through both FIFOs, and the filter-feed FSM states.
package audio_pkg;

    localparam int W_CODEC  = 24;
    localparam int W_SAMPLE = 16;

    typedef struct packed {
        logic signed [W_SAMPLE-1:0] left;
        logic signed [W_SAMPLE-1:0] right;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } feed_state_t;

    // The filter works on the most significant W_SAMPLE bits of each codec word.
    function automatic stereo_t codec_to_sample(input logic [W_CODEC-1:0] l,
                                                input logic [W_CODEC-1:0] r);
        stereo_t s;
        s.left  = l[W_CODEC-1 -: W_SAMPLE];
        s.right = r[W_CODEC-1 -: W_SAMPLE];
        return s;
    endfunction

    function automatic logic [W_CODEC-1:0] sample_to_codec(input logic [W_SAMPLE-1:0] s);
        return {s, {(W_CODEC-W_SAMPLE){1'b0}}};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous stereo-sample FIFO, DEPTH entries (power of two), with
// simultaneous push/pop and full/empty guards on both ports.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    ck,
    input  logic    rst_n,
    input  logic    push,
    input  stereo_t push_data,
    input  logic    pop,
    output stereo_t head,
    output logic    full,
    output logic    empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    stereo_t     mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit tells a full FIFO from an empty one when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: the storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge ck) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/codec_fir_bridge.sv
// Moves stereo samples from a 24-bit audio codec ADC through a 16-bit FIR
// filter and back to the codec DAC, reporting dropped results and filter stalls.
module codec_fir_bridge
    import audio_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                ck,
    input  logic                rst_n,
    input  logic                read_ready,
    input  logic [23:0]         readdata_left,
    input  logic [23:0]         readdata_right,
    output logic                read,
    input  logic                write_ready,
    output logic [23:0]         writedata_left,
    output logic [23:0]         writedata_right,
    output logic                write,
    output logic signed [15:0]  in_left,
    output logic signed [15:0]  in_right,
    output logic                input_ready,
    input  logic signed [15:0]  out_left,
    input  logic signed [15:0]  out_right,
    input  logic                output_ready,
    output logic                overflow,
    output logic                timeout
);

    localparam int            CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    feed_state_t   state_q;
    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    stereo_t       in_sample_q;
    logic          input_ready_q;
    logic          overflow_q;
    logic          timeout_q;

    stereo_t in_push_data;
    stereo_t in_head;
    logic    in_full;
    logic    in_empty;
    logic    in_pop;
    stereo_t out_push_data;
    stereo_t out_head;
    logic    out_full;
    logic    out_empty;
    logic    out_push;

    // Strobes are gated by rst_n so the codec sees no handshake while reset is held.
    assign read          = rst_n && read_ready && !in_full;
    assign write         = rst_n && write_ready && !out_empty;
    assign in_push_data  = codec_to_sample(readdata_left, readdata_right);
    assign in_pop        = (state_q == ISSUE);
    assign out_push_data = {out_left, out_right};
    assign out_push      = (state_q == WAIT) && output_ready && !out_full;
    assign wait_cnt_d    = wait_cnt_q + CNT_ONE;

    assign writedata_left  = out_empty ? '0 : sample_to_codec(out_head.left);
    assign writedata_right = out_empty ? '0 : sample_to_codec(out_head.right);
    assign in_left         = in_sample_q.left;
    assign in_right        = in_sample_q.right;
    assign input_ready     = input_ready_q;
    assign overflow        = overflow_q;
    assign timeout         = timeout_q;

    sample_fifo #(.DEPTH(DEPTH)) u_in_fifo (
        .ck        (ck),
        .rst_n     (rst_n),
        .push      (read),
        .push_data (in_push_data),
        .pop       (in_pop),
        .head      (in_head),
        .full      (in_full),
        .empty     (in_empty)
    );

    sample_fifo #(.DEPTH(DEPTH)) u_out_fifo (
        .ck        (ck),
        .rst_n     (rst_n),
        .push      (out_push),
        .push_data (out_push_data),
        .pop       (write),
        .head      (out_head),
        .full      (out_full),
        .empty     (out_empty)
    );

    // The filter sample and its strobe are captured on the IDLE->ISSUE edge, so
    // they are valid exactly while the FSM sits in ISSUE and the head is popped.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            input_ready_q <= 1'b0;
            in_sample_q   <= '0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            input_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!in_empty) begin
                        state_q       <= ISSUE;
                        input_ready_q <= 1'b1;
                        in_sample_q   <= in_head;
                    end
                end
                ISSUE: begin
                    state_q    <= WAIT;
                    wait_cnt_q <= '0;
                end
                WAIT: begin
                    if (output_ready) begin
                        state_q <= IDLE;
                        if (out_full) overflow_q <= 1'b1;
                    end else if (wait_cnt_d == CNT_LIMIT) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_fir_bridge.sv
// Bench for codec_fir_bridge: directed scenarios plus a randomized run, all
// checked against a transaction-level queue model of the two FIFOs and the filter.
module tb_codec_fir_bridge;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic               ck;
    logic               rst_n;
    logic               read_ready;
    logic [23:0]        readdata_left;
    logic [23:0]        readdata_right;
    logic               read;
    logic               write_ready;
    logic [23:0]        writedata_left;
    logic [23:0]        writedata_right;
    logic               write;
    logic signed [15:0] in_left;
    logic signed [15:0] in_right;
    logic               input_ready;
    logic signed [15:0] out_left;
    logic signed [15:0] out_right;
    logic               output_ready;
    logic               overflow;
    logic               timeout;

    codec_fir_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .ck              (ck),
        .rst_n           (rst_n),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write           (write),
        .in_left         (in_left),
        .in_right        (in_right),
        .input_ready     (input_ready),
        .out_left        (out_left),
        .out_right       (out_right),
        .output_ready    (output_ready),
        .overflow        (overflow),
        .timeout         (timeout)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: samples queued in each FIFO, one outstanding filter job.
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic        waiting;
    int          deadline;
    logic        exp_overflow;
    logic        exp_timeout;
    int          cyc = 0;
    int          stall;
    logic [31:0] issued;

    // Filter behaviour: 0 = never answers, 1 = fixed delay, 2 = random delay plus stray strobes.
    int          filt_mode  = 0;
    int          filt_delay = 1;
    int          resp_cnt;
    logic        fix_en     = 1'b0;
    logic [31:0] fix_val    = '0;

    int          n_read, n_issue, n_write, n_rd_block;
    int          last_read_cyc, last_issue_cyc, last_write_cyc, timeout_rise_cyc;
    logic [47:0] last_wdata;
    int          first_issue;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        waiting          = 1'b0;
        exp_overflow     = 1'b0;
        exp_timeout      = 1'b0;
        resp_cnt         = 0;
        stall            = 0;
        n_read           = 0;
        n_issue          = 0;
        n_write          = 0;
        n_rd_block       = 0;
        last_read_cyc    = -1;
        last_issue_cyc   = -1;
        last_write_cyc   = -1;
        timeout_rise_cyc = -1;
        last_wdata       = '0;
    endtask

    // Called at posedge+1; inputs for the cycle are already driven.
    task automatic do_reset();
        rst_n       = 1'b0;
        read_ready  = 1'b1;
        write_ready = 1'b1;
        #1;
        check("rst_read", read, 1'b0);
        check("rst_write", write, 1'b0);
        check("rst_input_ready", input_ready, 1'b0);
        check("rst_in_data", {in_left, in_right}, 32'h0);
        check("rst_wdata", {writedata_left, writedata_right}, 48'h0);
        check("rst_flags", {overflow, timeout}, 2'b00);
        model_reset();
        @(posedge ck); #1;
        @(posedge ck); #1;
        rst_n        = 1'b1;
        read_ready   = 1'b0;
        write_ready  = 1'b0;
        output_ready = 1'b0;
    endtask

    // Observe one cycle at the falling edge, update the model, then drive the filter.
    task automatic tick();
        logic        exp_rd;
        logic        exp_wr;
        logic        full_pre;
        logic [31:0] head;
        @(negedge ck);
        cyc++;
        if (waiting && cyc == deadline) begin
            exp_timeout = 1'b1;
            waiting     = 1'b0;
            resp_cnt    = 0;
        end
        exp_rd = read_ready && (in_q.size() < DEPTH);
        exp_wr = write_ready && (out_q.size() > 0);
        check("read", read, exp_rd);
        check("write", write, exp_wr);
        check("overflow", overflow, exp_overflow);
        check("timeout", timeout, exp_timeout);
        if (read_ready && !read) n_rd_block++;
        if (timeout && timeout_rise_cyc < 0) timeout_rise_cyc = cyc;

        full_pre = (out_q.size() == DEPTH);
        if (out_q.size() == 0) begin
            check("wdata_idle", {writedata_left, writedata_right}, 48'h0);
        end else if (write) begin
            head = out_q.pop_front();
            check("wdata", {writedata_left, writedata_right},
                  {head[31:16], 8'h00, head[15:0], 8'h00});
        end
        if (write) begin
            n_write++;
            last_write_cyc = cyc;
            last_wdata     = {writedata_left, writedata_right};
        end

        if (output_ready && waiting) begin
            waiting  = 1'b0;
            resp_cnt = 0;
            if (full_pre) exp_overflow = 1'b1;
            else          out_q.push_back({out_left, out_right});
        end

        if (input_ready) begin
            n_issue++;
            last_issue_cyc = cyc;
            issued         = {in_left, in_right};
            check("issue_ok", {waiting, in_q.size() == 0}, 2'b00);
            if (in_q.size() > 0) check("in_data", {in_left, in_right}, in_q.pop_front());
            waiting  = 1'b1;
            deadline = cyc + TIMEOUT;
            resp_cnt = (filt_mode == 1) ? filt_delay :
                       (filt_mode == 2) ? int'($urandom_range(1, 8)) : 0;
        end

        if (read) begin
            n_read++;
            last_read_cyc = cyc;
            in_q.push_back({readdata_left[23:8], readdata_right[23:8]});
        end

        stall = (!waiting && in_q.size() > 0 && !input_ready) ? stall + 1 : 0;
        check("issue_latency", stall <= 2, 1'b1);

        @(posedge ck); #1;
        output_ready = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                output_ready = 1'b1;
                {out_left, out_right} = fix_en ? fix_val
                                               : {issued[31:16] ^ 16'h0F0F, issued[15:0] + 16'd3};
            end
        end else if (filt_mode == 2 && !waiting && $urandom_range(0, 7) == 0) begin
            output_ready = 1'b1;
            {out_left, out_right} = $urandom;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        read_ready     = 1'b0;
        write_ready    = 1'b0;
        output_ready   = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        out_left       = '0;
        out_right      = '0;
        issued         = '0;
        model_reset();
        @(posedge ck); #1;

        // First sample travels to the filter two cycles after the read strobe.
        do_reset();
        filt_mode      = 0;
        read_ready     = 1'b1;
        readdata_left  = 24'h123456;
        readdata_right = 24'hABCDEF;
        tick();
        check("a_read_fired", last_read_cyc, cyc);
        read_ready = 1'b0;
        tick();
        tick();
        check("a_latency", last_issue_cyc - last_read_cyc, 2);
        check("a_in_left", issued[31:16], 16'h1234);
        check("a_in_right", issued[15:0], 16'hABCD);
        tick();
        check("a_in_hold", {input_ready, in_left, in_right}, {1'b0, 16'h1234, 16'hABCD});

        // Filter answers three cycles after input_ready; result reaches the DAC.
        do_reset();
        filt_mode      = 1;
        filt_delay     = 3;
        fix_en         = 1'b1;
        fix_val        = {16'h0A0B, 16'h0C0D};
        write_ready    = 1'b1;
        read_ready     = 1'b1;
        readdata_left  = 24'h777777;
        readdata_right = 24'h888888;
        tick();
        read_ready = 1'b0;
        for (int i = 0; i < 20 && n_write < 1; i++) tick();
        check("b_write_count", n_write, 1);
        check("b_wdata", last_wdata, {24'h0A0B00, 24'h0C0D00});
        check("b_write_latency", last_write_cyc - last_issue_cyc, 4);
        fix_en = 1'b0;

        // DAC stalled: four results fit, the fifth is dropped and flagged.
        do_reset();
        filt_mode  = 1;
        filt_delay = 2;
        read_ready = 1'b1;
        for (int i = 0; i < 100 && n_read < 5; i++) begin
            readdata_left  = 24'($urandom);
            readdata_right = 24'($urandom);
            tick();
        end
        read_ready = 1'b0;
        for (int i = 0; i < 200 && !(n_issue == 5 && !waiting); i++) tick();
        check("c_issued", n_issue, 5);
        tick();
        check("c_overflow", overflow, 1'b1);
        write_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("c_writes", n_write, 4);

        // Silent filter: timeout after 64 cycles, then the next sample is served.
        do_reset();
        filt_mode  = 0;
        read_ready = 1'b1;
        tick();
        readdata_left = 24'h345678;
        tick();
        read_ready = 1'b0;
        for (int i = 0; i < 10 && n_issue < 1; i++) tick();
        first_issue = last_issue_cyc;
        for (int i = 0; i < 100 && n_issue < 2; i++) tick();
        check("d_issued", n_issue, 2);
        check("d_timeout_rise", timeout_rise_cyc - first_issue, TIMEOUT);
        check("d_next_issue", last_issue_cyc - first_issue, TIMEOUT + 1);

        // Full input FIFO with a blocked filter: back-pressure, order preserved.
        do_reset();
        filt_mode  = 0;
        read_ready = 1'b1;
        for (int i = 0; i < 1000 && n_read < 8; i++) begin
            readdata_left  = 24'($urandom);
            readdata_right = 24'($urandom);
            tick();
        end
        read_ready = 1'b0;
        for (int i = 0; i < 1000 && n_issue < 8; i++) tick();
        check("e_reads", n_read, 8);
        check("e_issued", n_issue, 8);
        check("e_backpressure", n_rd_block > 0, 1'b1);

        // Reset while waiting on the filter; the late answer must vanish.
        do_reset();
        filt_mode   = 1;
        filt_delay  = 5;
        write_ready = 1'b1;
        read_ready  = 1'b1;
        tick();
        read_ready = 1'b0;
        for (int i = 0; i < 10 && n_issue < 1; i++) tick();
        tick();
        tick();
        do_reset();
        write_ready  = 1'b1;
        output_ready = 1'b1;
        out_left     = 16'h1111;
        out_right    = 16'h2222;
        for (int i = 0; i < 6; i++) tick();
        check("f_no_write", n_write, 0);
        check("f_outputs_zero", {write, input_ready, in_left, in_right, overflow, timeout}, 36'h0);
        check("f_wdata_zero", {writedata_left, writedata_right}, 48'h0);

        // Randomized traffic with stray filter strobes, then drain.
        do_reset();
        filt_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            read_ready     = 1'($urandom_range(0, 1));
            write_ready    = ($urandom_range(0, 3) != 0);
            readdata_left  = 24'($urandom);
            readdata_right = 24'($urandom);
            tick();
        end
        read_ready  = 1'b0;
        write_ready = 1'b1;
        for (int i = 0; i < 500 && (in_q.size() > 0 || out_q.size() > 0 || waiting); i++) tick();
        check("g_drained", {in_q.size(), out_q.size(), 31'(waiting)}, 95'h0);
        check("g_activity", n_write > 100, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/codec_fir_bridge.md
CODEC_FIR_BRIDGE -- requirements
Module: codec_fir_bridge

Interface
REQ-001 Parameter DEPTH, default 4: entries (stereo pairs) in each of the input and output FIFOs; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles in WAIT for filter output_ready.
REQ-003 ck  in  1  single clock for all logic.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 read_ready  in  1  codec has an ADC stereo sample available.
REQ-006 readdata_left, readdata_right  in  24 each  codec ADC samples.
REQ-007 read  out  1  codec read strobe.
REQ-008 write_ready  in  1  codec can accept a DAC stereo sample.
REQ-009 writedata_left, writedata_right  out  24 each  codec DAC samples.
REQ-010 write  out  1  codec write strobe.
REQ-011 in_left, in_right  out  16 signed each  filter input samples.
REQ-012 input_ready  out  1  one-cycle strobe; in_left/in_right valid.
REQ-013 out_left, out_right  in  16 signed each  filter outputs.
REQ-014 output_ready  in  1  one-cycle strobe; out_left/out_right valid.
REQ-015 overflow  out  1  sticky flag: a filter result was dropped.
REQ-016 timeout  out  1  sticky flag: the filter failed to respond within TIMEOUT cycles.

Function
REQ-017 read SHALL equal read_ready AND NOT input-FIFO-full (combinational); on each ck edge with read=1, {readdata_left[23:8], readdata_right[23:8]} SHALL be pushed into the input FIFO.
REQ-018 read SHALL stay 0 while the input FIFO is full, even in a cycle where a pop occurs.
REQ-019 The feed FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-020 IDLE->ISSUE SHALL occur when the input FIFO is non-empty.
REQ-021 In ISSUE, input_ready=1 for exactly one cycle, in_left/in_right SHALL hold the FIFO head, the head SHALL be popped, and the next state SHALL be WAIT.
REQ-022 in_left/in_right SHALL remain registered at their last value outside ISSUE.
REQ-023 Latency: a sample pushed at edge N into an empty FIFO with the FSM in IDLE SHALL produce input_ready=1 in cycle N+2.
REQ-024 WAIT->IDLE on output_ready=1: {out_left, out_right} SHALL be pushed into the output FIFO.
REQ-025 If the output FIFO is full when output_ready=1, the pair SHALL be dropped and overflow SHALL be set.
REQ-026 output_ready outside WAIT SHALL be ignored and SHALL NOT set any flag.
REQ-027 The WAIT cycle counter SHALL start at 0 on entry; on reaching TIMEOUT-1 without output_ready, timeout SHALL be set and the FSM SHALL return to IDLE with no push.
REQ-028 write SHALL equal write_ready AND NOT output-FIFO-empty (combinational); writedata_left/writedata_right SHALL equal {head sample, 8'h00}; the head SHALL pop on each edge with write=1.
REQ-029 Each FIFO SHALL support simultaneous push and pop; occupancy SHALL be unchanged and pointers SHALL wrap modulo DEPTH.
REQ-030 A push to a full FIFO or a pop from an empty FIFO SHALL NOT occur.

Reset
REQ-031 rst_n=0 SHALL asynchronously force the FSM to IDLE, empty both FIFOs, clear the WAIT counter, and clear overflow and timeout.
REQ-032 rst_n=0 SHALL force input_ready=0 and in_left=in_right=0.
REQ-033 rst_n=0 SHALL force read=0, write=0 and writedata_left=writedata_right=0.
REQ-034 A reset asserted mid-WAIT SHALL discard the pending result; a later output_ready SHALL be ignored.
REQ-035 Flags SHALL clear only on reset.

Structure
REQ-036 Package audio_pkg SHALL hold W_CODEC=24, W_SAMPLE=16, the stereo_t packed struct {left, right}, and the feed_state_t enum.
REQ-037 Sub-module sample_fifo (parameter DEPTH, stereo_t data, push, pop, full, empty) SHALL be instantiated twice: once for the input FIFO and once for the output FIFO.

Verification
REQ-038 Reset, then read_ready=1 with readdata_left=24'h123456: read=1, and input_ready pulses 2 cycles later with in_left=16'h1234.
REQ-039 Filter model answering out_left=16'h0A0B after 3 cycles, write_ready=1: write=1, and writedata_left=24'h0A0B00.
REQ-040 write_ready=0, 5 filter results: output FIFO holds 4, the 5th is dropped, and overflow=1.
REQ-041 Filter never asserts output_ready: timeout=1 exactly 64 cycles after input_ready, and the FSM then serves the next queued sample.
REQ-042 Input FIFO full, filter blocked, read_ready=1: read stays 0 until a pop, with no data loss or reordering over 8 samples.
REQ-043 rst_n=0 asserted in WAIT, then output_ready pulsed: no write occurs and all outputs are 0.
